// File: rtl/frame_rev_pkg.sv
// Shared definitions for the frame reverser: element ordering modes and
// the counter-width helper used to size element indices.
package frame_rev_pkg;

    typedef enum logic {
        MODE_REVERSE = 1'b0,
        MODE_PASS    = 1'b1
    } mode_e;

    // Bits needed to index N elements; never below 1 so ports stay legal.
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/frame_rev_bank.sv
// One ping-pong bank: N elements of WIDTH bits, a single write port and a
// combinational read port.
module frame_rev_bank
    import frame_rev_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 8,
    localparam int CW   = cnt_width(N)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [N];

    // NOTE: storage has no reset; the full flags in the parent decide when
    // contents are meaningful, so clearing data would only cost a reset net.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_reverser.sv
// Collects fixed-length frames of N elements into ping-pong banks and emits
// each frame either reversed or in order, selected per frame by mode.
module frame_reverser
    import frame_rev_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]       full;
    mode_e            bank_mode [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [CW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_cnt;

    logic             in_fire;
    logic             out_fire;
    mode_e            rd_mode;
    logic [CW-1:0]    raddr;
    logic [WIDTH-1:0] rdata [2];

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Both banks see the same read index; only the selected bank's word is used.
    assign rd_mode  = bank_mode[rd_bank];
    assign raddr    = (rd_mode == MODE_PASS) ? rd_cnt : LAST - rd_cnt;
    assign out_data = rdata[rd_bank];
    assign out_last = out_valid & (rd_cnt == LAST);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_rev_bank #(
            .N     (N),
            .WIDTH (WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (in_fire && (wr_bank == 1'(b))),
            .waddr (wr_cnt),
            .wdata (in_data),
            .raddr (raddr),
            .rdata (rdata[b])
        );
    end

    // NOTE: all state uses non-blocking assignments so every update in this
    // block sees the pre-edge values, matching the flop behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= 2'b00;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            bank_mode[0] <= MODE_REVERSE;
            bank_mode[1] <= MODE_REVERSE;
        end else begin
            if (in_fire) begin
                if (wr_cnt == '0) begin
                    bank_mode[wr_bank] <= mode_e'(mode);
                end
                if (wr_cnt == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_cnt        <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // Set and clear always hit different banks: a bank being written
            // is empty, a bank being drained is full.
            if (out_fire) begin
                if (rd_cnt == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_cnt        <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_reverser.sv
// Directed bench for frame_reverser with N=5, WIDTH=8: reverse and pass
// frames, back-to-back streaming, back-pressure, mid-frame reset, mode churn.
module tb_frame_reverser;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    frame_reverser #(.N(5), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic l);
        check({tag, "_valid"}, out_valid, v);
        if (v) check({tag, "_data"}, out_data, d);
        check({tag, "_last"}, out_last, l);
    endtask

    // Apply inputs just after a rising edge, return at the falling edge so
    // the caller samples outputs for the cycle these inputs belong to.
    task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        mode      = m;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        clk = 0; rst = 1; mode = 0; in_valid = 0; in_data = 0; out_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        drive(0, 8'h00, 0, 1);
        check("rst_in_ready", in_ready, 1);
        check_out("rst_out", 0, 8'h00, 0);

        // Reverse frame 01..05
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h01 + i), 0, 1);
            check($sformatf("t1_in_ready%0d", i), in_ready, 1);
            check($sformatf("t1_novalid%0d", i), out_valid, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 1);
            check_out($sformatf("t1_out%0d", i), 1, 8'(8'h05 - i), i == 4);
        end
        drive(0, 8'h00, 0, 1);
        check_out("t1_idle", 0, 8'h00, 0);

        // Pass-through frame 0A..0E
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h0A + i), 1, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 1);
            check_out($sformatf("t2_out%0d", i), 1, 8'(8'h0A + i), i == 4);
        end

        // Back-to-back: A reverse, B pass, no gaps
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h10 + i), 0, 1);
            check($sformatf("t3_a_in_ready%0d", i), in_ready, 1);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h20 + i), 1, 1);
            check($sformatf("t3_b_in_ready%0d", i), in_ready, 1);
            check_out($sformatf("t3_a_out%0d", i), 1, 8'(8'h14 - i), i == 4);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 1);
            check_out($sformatf("t3_b_out%0d", i), 1, 8'(8'h20 + i), i == 4);
        end
        drive(0, 8'h00, 0, 1);
        check_out("t3_idle", 0, 8'h00, 0);

        // Back-pressure: three frames offered with out_ready low
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0);
            check($sformatf("t4_fill_ready%0d", i), in_ready, 1);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 8'h4A, 0, 0);
            check($sformatf("t4_stall_ready%0d", i), in_ready, 0);
            check_out($sformatf("t4_hold%0d", i), 1, 8'h44, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h4A, 0, 1);
            check($sformatf("t4_drain_ready%0d", i), in_ready, 0);
            check_out($sformatf("t4_f1_out%0d", i), 1, 8'(8'h44 - i), i == 4);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h4A + i), 0, 1);
            check($sformatf("t4_resume_ready%0d", i), in_ready, 1);
            check_out($sformatf("t4_f2_out%0d", i), 1, 8'(8'h49 - i), i == 4);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 1);
            check_out($sformatf("t4_f3_out%0d", i), 1, 8'(8'h4E - i), i == 4);
        end
        drive(0, 8'h00, 0, 1);
        check_out("t4_idle", 0, 8'h00, 0);

        // Reset with one undrained frame and a partial frame pending
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h50 + i), 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 8'(8'h60 + i), 1, 0);
        drive(0, 8'h00, 0, 0);
        check_out("t5_pre_rst", 1, 8'h50, 0);
        rst = 1;
        drive(0, 8'h00, 0, 0);
        rst = 0;
        check("t5_rst_in_ready", in_ready, 1);
        check_out("t5_rst_out", 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h31 + i), 0, 1);
            check($sformatf("t5_novalid%0d", i), out_valid, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 1, 1);
            check_out($sformatf("t5_out%0d", i), 1, 8'(8'h35 - i), i == 4);
        end
        drive(0, 8'h00, 0, 1);
        check_out("t5_idle", 0, 8'h00, 0);

        // Mode toggling mid-frame is ignored
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h70 + i), 1'(i % 2), 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 1'((i + 1) % 2), 1);
            check_out($sformatf("t6_out%0d", i), 1, 8'(8'h74 - i), i == 4);
        end
        drive(0, 8'h00, 0, 1);
        check_out("t6_idle", 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_reverser.md
FRAME_REVERSER -- requirements
Module: frame_reverser

Interface
REQ-001 Parameter N, default 5, elements per frame; legal range 2..256.
REQ-002 Parameter WIDTH, default 8, bits per element; legal range 1..64.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 mode  input  1  0 = reverse, 1 = pass-through; sampled only with the first element of each frame.
REQ-006 in_valid  input  1  in_data holds a valid element.
REQ-007 in_ready  output  1  block can accept an element this cycle.
REQ-008 in_data  input  WIDTH  element value.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element this cycle.
REQ-011 out_data  output  WIDTH  element value.
REQ-012 out_last  output  1  high with the final element of each output frame.

Function
REQ-013 An input transfer SHALL occur on any cycle where in_valid and in_ready are both high; an output transfer on any cycle where out_valid and out_ready are both high.
REQ-014 A frame SHALL be exactly N consecutive input transfers; there is no input framing signal.
REQ-015 Storage SHALL be two banks of N x WIDTH (ping-pong), each with a full flag and a stored mode bit.
REQ-016 Write side: wr_bank and wr_cnt (0..N-1); element k of a frame SHALL be written to index k of wr_bank.
REQ-017 On the transfer with wr_cnt==0, mode SHALL be captured into that bank's mode bit.
REQ-018 On the transfer with wr_cnt==N-1: set the bank's full flag, toggle wr_bank, clear wr_cnt to 0.
REQ-019 in_ready SHALL equal NOT full[wr_bank].
REQ-020 Read side: rd_bank and rd_cnt (0..N-1); out_valid SHALL equal full[rd_bank].
REQ-021 out_data SHALL be bank[rd_bank][N-1-rd_cnt] when the stored mode is 0, and bank[rd_bank][rd_cnt] when it is 1.
REQ-022 out_last SHALL equal out_valid AND (rd_cnt==N-1).
REQ-023 On an output transfer with rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, clear rd_cnt to 0; otherwise an output transfer increments rd_cnt.
REQ-024 Latency: the first output element of a frame SHALL be valid in the cycle after that frame's last input transfer, provided the previous frame has fully drained.
REQ-025 Sustained throughput SHALL be one element per cycle in each direction when out_ready is held high.
REQ-026 Setting a full flag on one bank and clearing the other bank's flag in the same cycle SHALL both take effect.
REQ-027 When both banks are full, in_ready SHALL be 0 until the read side clears a bank; in_ready SHALL rise the cycle after that clear.
REQ-028 When out_ready is low, out_data and out_last SHALL remain stable while out_valid is high.
REQ-029 mode changes in the middle of a frame SHALL have no effect on that frame.

Reset
REQ-030 While rst is high at a clock edge: both full flags 0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, mode bits 0.
REQ-031 After reset, out_valid and out_last SHALL be 0 and in_ready SHALL be 1 from the first cycle.
REQ-032 Reset mid-frame SHALL discard any partial input frame and any undrained output frame; bank data contents need not be cleared.

Structure
REQ-033 Package frame_rev_pkg SHALL hold the mode constants MODE_REVERSE=0 and MODE_PASS=1 and a function computing counter width as clog2(N).
REQ-034 Sub-module frame_rev_bank SHALL implement one bank: N x WIDTH registers, one write port, one combinational read port; frame_reverser instantiates it twice.
REQ-035 The flag and counter control logic SHALL live in frame_reverser; no other hierarchy.

Verification (N=5, WIDTH=8)
REQ-036 Reset, then mode=0, inputs 01,02,03,04,05, out_ready=1 -> outputs 05,04,03,02,01; out_last on 01; first out_valid one cycle after 05 is accepted.
REQ-037 mode=1, inputs 0A..0E -> outputs 0A..0E in order; out_last on 0E.
REQ-038 Back-to-back frames A (10..14, reverse) and B (20..24, pass) with continuous in_valid and out_ready -> in_ready stays 1; output 14..10 then 20..24 with no gap cycles.
REQ-039 out_ready=0 while 3 frames are offered -> after 10 transfers in_ready=0 and the 11th element stalls; out_ready=1 -> in_ready returns 1 the cycle after the 5th output; all data correct.
REQ-040 rst pulsed after 3 elements of a frame -> out_valid=0 and in_ready=1; a following frame 31..35 in reverse mode -> 35..31 with no residue of the earlier elements.
REQ-041 mode toggled on every cycle during a frame started with mode=0 -> whole frame is output reversed.
